// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants and helpers for the TLB-based MMU.
//   MODE_BARE / MODE_TRANSLATE : values of the translation-mode register
//   page_field_w()             : width of the VPN/PPN field for a given page-offset width
package mmu_pkg;

    localparam logic        MODE_BARE      = 1'b0;
    localparam logic        MODE_TRANSLATE = 1'b1;
    localparam int unsigned ADDR_W         = 32;

    function automatic int unsigned page_field_w(input int unsigned page_bits);
        return ADDR_W - page_bits;
    endfunction

endpackage

// File: rtl/mmu_tlb_if.sv
// mmu_tlb_if: memory-side bus bundle (instruction read, data read, data write, stall).
//   master : issues requests (inst/data read, data write), receives returns and stall
//   slave  : receives requests, drives returns and stall
// The MMU sits between two instances: slave towards the core, master towards memory.
interface mmu_tlb_if;

    logic        inst_rden;
    logic [31:0] inst_riaddr;
    logic [31:0] inst_roaddr;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_rden;
    logic [31:0] data_riaddr;
    logic [31:0] data_roaddr;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        data_wren;
    logic [31:0] data_waddr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;

    logic        stall;

    modport master (
        output inst_rden, inst_riaddr, data_rden, data_riaddr,
               data_wren, data_waddr, data_wstrb, data_wdata,
        input  inst_roaddr, inst_rvalid, inst_rdata,
               data_roaddr, data_rvalid, data_rdata, stall
    );

    modport slave (
        input  inst_rden, inst_riaddr, data_rden, data_riaddr,
               data_wren, data_waddr, data_wstrb, data_wdata,
        output inst_roaddr, inst_rvalid, inst_rdata,
               data_roaddr, data_rvalid, data_rdata, stall
    );

endinterface

// File: rtl/mmu_tlb_cam.sv
// mmu_tlb_cam: fully associative TLB entry array with three parallel lookup ports.
//   clk, rst_n              : clock, asynchronous active-low reset (clears valid bits and pointer)
//   fill_en_i/vpn_i/ppn_i   : write one entry (in place if VPN resident, else round-robin victim)
//   flush_i                 : invalidate all entries, reset pointer; overrides a same-cycle fill
//   lookup_vpn_i[p]         : lookup VPN per port (0 inst, 1 data read, 2 data write)
//   hit_o[p], ppn_o[p]      : combinational match result per port (pre-update state)
module mmu_tlb_cam
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES   = 4,
    parameter int unsigned PAGE_BITS = 12,
    localparam int unsigned VW       = page_field_w(PAGE_BITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fill_en_i,
    input  logic [VW-1:0]      fill_vpn_i,
    input  logic [VW-1:0]      fill_ppn_i,
    input  logic               flush_i,
    input  logic [2:0][VW-1:0] lookup_vpn_i,
    output logic [2:0]         hit_o,
    output logic [2:0][VW-1:0] ppn_o
);

    localparam int unsigned PW = $clog2(ENTRIES);

    logic [ENTRIES-1:0]         valid_q, valid_d;
    logic [ENTRIES-1:0][VW-1:0] vpn_q;
    logic [ENTRIES-1:0][VW-1:0] ppn_q;
    logic [PW-1:0]              ptr_q, ptr_d;

    logic          fill_match;
    logic [PW-1:0] fill_idx;
    logic [PW-1:0] widx;
    logic          we;

    // A resident VPN is refreshed in place so the array never holds duplicates.
    always_comb begin
        fill_match = 1'b0;
        fill_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!fill_match && valid_q[i] && (vpn_q[i] == fill_vpn_i)) begin
                fill_match = 1'b1;
                fill_idx   = PW'(i);
            end
        end
    end

    assign we   = fill_en_i & ~flush_i;
    assign widx = fill_match ? fill_idx : ptr_q;

    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (fill_en_i) begin
            valid_d[widx] = 1'b1;
            if (!fill_match) begin
                ptr_d = (ptr_q == PW'(ENTRIES - 1)) ? '0 : ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    // Tag/data storage needs no reset: every read is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (we) begin
            vpn_q[widx] <= fill_vpn_i;
            ppn_q[widx] <= fill_ppn_i;
        end
    end

    always_comb begin
        hit_o = '0;
        ppn_o = '0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (valid_q[i] && (vpn_q[i] == lookup_vpn_i[p])) begin
                    hit_o[p] = 1'b1;
                    ppn_o[p] = ppn_o[p] | ppn_q[i];
                end
            end
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: translating MMU between core (main_if) and memory (mem_if).
//   clk, rst_n              : clock, asynchronous active-low reset
//   mode_we_i, mode_wd_i    : translation-mode register write (0 bare, 1 translate)
//   fill_en_i/vpn_i/ppn_i   : TLB entry fill
//   flush_i                 : invalidate all TLB entries
//   inst_fault_o/data_fault_o : one-cycle miss pulses, cycle after the missing request
//   fault_addr_o            : virtual address of the most recent miss (data wins over inst)
//   hit_cnt_o/miss_cnt_o    : saturating lookup counters, only with MMU_TLB_PERF_EN defined
//   main_if (slave)         : core-side requests/returns, virtual addresses
//   mem_if (master)         : memory-side requests/returns, physical addresses
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int unsigned ENTRIES    = 4,
    parameter int unsigned PAGE_BITS  = 12,
    parameter int unsigned RESET_MODE = 0,
    localparam int unsigned VW        = page_field_w(PAGE_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode_we_i,
    input  logic          mode_wd_i,
    input  logic          fill_en_i,
    input  logic [VW-1:0] fill_vpn_i,
    input  logic [VW-1:0] fill_ppn_i,
    input  logic          flush_i,
    output logic          inst_fault_o,
    output logic          data_fault_o,
    output logic [31:0]   fault_addr_o,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o,
    mmu_tlb_if.slave      main_if,
    mmu_tlb_if.master     mem_if
);

    localparam logic MODE_RST = (RESET_MODE != 0) ? MODE_TRANSLATE : MODE_BARE;

    logic               mode_q, mode_d;
    logic [VW-1:0]      inst_vpn_q, inst_vpn_d;
    logic [VW-1:0]      data_vpn_q, data_vpn_d;
    logic               inst_fault_q, inst_fault_d;
    logic               data_fault_q, data_fault_d;
    logic [31:0]        fault_addr_q, fault_addr_d;

    logic [2:0][VW-1:0] lk_vpn;
    logic [2:0]         lk_hit;
    logic [2:0][VW-1:0] lk_ppn;
    logic               translate;
    logic               stall;
    logic               inst_miss, rd_miss, wr_miss;

    assign lk_vpn[0] = main_if.inst_riaddr[31:PAGE_BITS];
    assign lk_vpn[1] = main_if.data_riaddr[31:PAGE_BITS];
    assign lk_vpn[2] = main_if.data_waddr[31:PAGE_BITS];

    mmu_tlb_cam #(
        .ENTRIES   (ENTRIES),
        .PAGE_BITS (PAGE_BITS)
    ) u_cam (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_en_i    (fill_en_i),
        .fill_vpn_i   (fill_vpn_i),
        .fill_ppn_i   (fill_ppn_i),
        .flush_i      (flush_i),
        .lookup_vpn_i (lk_vpn),
        .hit_o        (lk_hit),
        .ppn_o        (lk_ppn)
    );

    assign translate = (mode_q == MODE_TRANSLATE);
    assign stall     = mem_if.stall;

    assign inst_miss = translate & main_if.inst_rden & ~lk_hit[0];
    assign rd_miss   = translate & main_if.data_rden & ~lk_hit[1];
    assign wr_miss   = translate & main_if.data_wren & ~lk_hit[2];

    // Request path: a missing request is squashed rather than sent untranslated.
    assign mem_if.inst_rden   = main_if.inst_rden & ~inst_miss;
    assign mem_if.data_rden   = main_if.data_rden & ~rd_miss;
    assign mem_if.data_wren   = main_if.data_wren & ~wr_miss;
    assign mem_if.inst_riaddr = (translate && lk_hit[0])
                              ? {lk_ppn[0], main_if.inst_riaddr[PAGE_BITS-1:0]}
                              : main_if.inst_riaddr;
    assign mem_if.data_riaddr = (translate && lk_hit[1])
                              ? {lk_ppn[1], main_if.data_riaddr[PAGE_BITS-1:0]}
                              : main_if.data_riaddr;
    assign mem_if.data_waddr  = (translate && lk_hit[2])
                              ? {lk_ppn[2], main_if.data_waddr[PAGE_BITS-1:0]}
                              : main_if.data_waddr;
    assign mem_if.data_wstrb  = main_if.data_wstrb;
    assign mem_if.data_wdata  = main_if.data_wdata;

    // Return path: with one outstanding read per channel, the held VPN names the page.
    assign main_if.inst_roaddr = translate
                               ? {inst_vpn_q, mem_if.inst_roaddr[PAGE_BITS-1:0]}
                               : mem_if.inst_roaddr;
    assign main_if.data_roaddr = translate
                               ? {data_vpn_q, mem_if.data_roaddr[PAGE_BITS-1:0]}
                               : mem_if.data_roaddr;
    assign main_if.inst_rvalid = mem_if.inst_rvalid;
    assign main_if.inst_rdata  = mem_if.inst_rdata;
    assign main_if.data_rvalid = mem_if.data_rvalid;
    assign main_if.data_rdata  = mem_if.data_rdata;
    assign main_if.stall       = mem_if.stall;

    always_comb begin
        mode_d       = mode_q;
        inst_vpn_d   = inst_vpn_q;
        data_vpn_d   = data_vpn_q;
        inst_fault_d = 1'b0;
        data_fault_d = 1'b0;
        fault_addr_d = fault_addr_q;
        if (!stall) begin
            if (mode_we_i) mode_d = mode_wd_i;
            if (mem_if.inst_rden) inst_vpn_d = lk_vpn[0];
            if (mem_if.data_rden) data_vpn_d = lk_vpn[1];
            inst_fault_d = inst_miss;
            data_fault_d = rd_miss | wr_miss;
            if (rd_miss) begin
                fault_addr_d = main_if.data_riaddr;
            end else if (wr_miss) begin
                fault_addr_d = main_if.data_waddr;
            end else if (inst_miss) begin
                fault_addr_d = main_if.inst_riaddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_RST;
            inst_vpn_q   <= '0;
            data_vpn_q   <= '0;
            inst_fault_q <= 1'b0;
            data_fault_q <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            mode_q       <= mode_d;
            inst_vpn_q   <= inst_vpn_d;
            data_vpn_q   <= data_vpn_d;
            inst_fault_q <= inst_fault_d;
            data_fault_q <= data_fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign inst_fault_o = inst_fault_q;
    assign data_fault_o = data_fault_q;
    assign fault_addr_o = fault_addr_q;

`ifdef MMU_TLB_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [1:0]  n_hit, n_miss;
    logic [32:0] hit_sum, miss_sum;

    always_comb begin
        n_hit  = 2'd0;
        n_miss = 2'd0;
        if (translate && !stall) begin
            if (main_if.inst_rden) begin
                if (lk_hit[0]) n_hit = n_hit + 2'd1; else n_miss = n_miss + 2'd1;
            end
            if (main_if.data_rden) begin
                if (lk_hit[1]) n_hit = n_hit + 2'd1; else n_miss = n_miss + 2'd1;
            end
            if (main_if.data_wren) begin
                if (lk_hit[2]) n_hit = n_hit + 2'd1; else n_miss = n_miss + 2'd1;
            end
        end
        hit_sum    = {1'b0, hit_cnt_q} + 33'(n_hit);
        miss_sum   = {1'b0, miss_cnt_q} + 33'(n_miss);
        hit_cnt_d  = hit_sum[32] ? '1 : hit_sum[31:0];
        miss_cnt_d = miss_sum[32] ? '1 : miss_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed bench for mmu_tlb with a page-map reference model
// (FIFO of resident pages + associative VPN->PPN map) checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mmu_tlb;

    localparam int unsigned ENTRIES   = 4;
    localparam int unsigned PAGE_BITS = 12;
    localparam int unsigned VW        = 32 - PAGE_BITS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode_we, mode_wd, fill_en, flush;
    logic [VW-1:0] fill_vpn, fill_ppn;
    logic          inst_fault, data_fault;
    logic [31:0]   fault_addr, hit_cnt, miss_cnt;

    mmu_tlb_if main_bus ();
    mmu_tlb_if mem_bus ();

    always #5 clk = ~clk;

    mmu_tlb #(
        .ENTRIES    (ENTRIES),
        .PAGE_BITS  (PAGE_BITS),
        .RESET_MODE (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_we_i    (mode_we),
        .mode_wd_i    (mode_wd),
        .fill_en_i    (fill_en),
        .fill_vpn_i   (fill_vpn),
        .fill_ppn_i   (fill_ppn),
        .flush_i      (flush),
        .inst_fault_o (inst_fault),
        .data_fault_o (data_fault),
        .fault_addr_o (fault_addr),
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt),
        .main_if      (main_bus),
        .mem_if       (mem_bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic          m_mode = 1'b0;
    logic [VW-1:0] m_order[$];
    logic [VW-1:0] m_ppn[logic [VW-1:0]];
    logic [VW-1:0] m_inst_vpn = '0, m_data_vpn = '0;
    logic          m_inst_fault = 1'b0, m_data_fault = 1'b0;
    logic [31:0]   m_fault_addr = '0;
    longint        m_hits = 0, m_misses = 0;
    bit            u_ih, u_rh, u_wh, u_im, u_rm, u_wm;

    function automatic bit resident(input logic [31:0] a);
        return m_ppn.exists(a[31:PAGE_BITS]);
    endfunction

    // Virtual->physical per the model; only called for bare mode or a resident page.
    function automatic logic [31:0] xl(input logic [31:0] a);
        if (!m_mode) return a;
        return {m_ppn[a[31:PAGE_BITS]], a[PAGE_BITS-1:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 1'b0;
            m_order.delete();
            m_ppn.delete();
            m_inst_vpn = '0;
            m_data_vpn = '0;
            m_inst_fault = 1'b0;
            m_data_fault = 1'b0;
            m_fault_addr = '0;
            m_hits = 0;
            m_misses = 0;
        end else begin
            u_ih = resident(main_bus.inst_riaddr);
            u_rh = resident(main_bus.data_riaddr);
            u_wh = resident(main_bus.data_waddr);
            u_im = m_mode && main_bus.inst_rden && !u_ih;
            u_rm = m_mode && main_bus.data_rden && !u_rh;
            u_wm = m_mode && main_bus.data_wren && !u_wh;
            m_inst_fault = 1'b0;
            m_data_fault = 1'b0;
            if (!mem_bus.stall) begin
                m_inst_fault = u_im;
                m_data_fault = u_rm || u_wm;
                if (u_rm) m_fault_addr = main_bus.data_riaddr;
                else if (u_wm) m_fault_addr = main_bus.data_waddr;
                else if (u_im) m_fault_addr = main_bus.inst_riaddr;
                if (m_mode) begin
                    m_hits += (main_bus.inst_rden && u_ih) + (main_bus.data_rden && u_rh)
                            + (main_bus.data_wren && u_wh);
                    m_misses += u_im + u_rm + u_wm;
                end
                if (main_bus.inst_rden && !u_im) m_inst_vpn = main_bus.inst_riaddr[31:PAGE_BITS];
                if (main_bus.data_rden && !u_rm) m_data_vpn = main_bus.data_riaddr[31:PAGE_BITS];
                if (mode_we) m_mode = mode_wd;
            end
            if (flush) begin
                m_order.delete();
                m_ppn.delete();
            end else if (fill_en) begin
                if (!m_ppn.exists(fill_vpn)) begin
                    if (m_order.size() == ENTRIES) m_ppn.delete(m_order.pop_front());
                    m_order.push_back(fill_vpn);
                end
                m_ppn[fill_vpn] = fill_ppn;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit c_ir, c_dr, c_dw;
    always @(negedge clk) begin
        c_ir = main_bus.inst_rden && !(m_mode && !resident(main_bus.inst_riaddr));
        c_dr = main_bus.data_rden && !(m_mode && !resident(main_bus.data_riaddr));
        c_dw = main_bus.data_wren && !(m_mode && !resident(main_bus.data_waddr));
        chk("mem_inst_rden", mem_bus.inst_rden, c_ir);
        chk("mem_data_rden", mem_bus.data_rden, c_dr);
        chk("mem_data_wren", mem_bus.data_wren, c_dw);
        if (c_ir) chk("mem_inst_riaddr", mem_bus.inst_riaddr, xl(main_bus.inst_riaddr));
        if (c_dr) chk("mem_data_riaddr", mem_bus.data_riaddr, xl(main_bus.data_riaddr));
        if (c_dw) chk("mem_data_waddr", mem_bus.data_waddr, xl(main_bus.data_waddr));
        chk("mem_data_wstrb", mem_bus.data_wstrb, main_bus.data_wstrb);
        chk("mem_data_wdata", mem_bus.data_wdata, main_bus.data_wdata);
        chk("main_inst_roaddr", main_bus.inst_roaddr, m_mode
            ? {m_inst_vpn, mem_bus.inst_roaddr[PAGE_BITS-1:0]} : mem_bus.inst_roaddr);
        chk("main_data_roaddr", main_bus.data_roaddr, m_mode
            ? {m_data_vpn, mem_bus.data_roaddr[PAGE_BITS-1:0]} : mem_bus.data_roaddr);
        chk("main_inst_rvalid", main_bus.inst_rvalid, mem_bus.inst_rvalid);
        chk("main_inst_rdata", main_bus.inst_rdata, mem_bus.inst_rdata);
        chk("main_data_rvalid", main_bus.data_rvalid, mem_bus.data_rvalid);
        chk("main_data_rdata", main_bus.data_rdata, mem_bus.data_rdata);
        chk("mmu_wait", main_bus.stall, mem_bus.stall);
        chk("inst_fault", inst_fault, m_inst_fault);
        chk("data_fault", data_fault, m_data_fault);
        chk("fault_addr", fault_addr, m_fault_addr);
`ifdef MMU_TLB_PERF_EN
        chk("hit_cnt", hit_cnt, 32'(m_hits));
        chk("miss_cnt", miss_cnt, 32'(m_misses));
`else
        chk("hit_cnt", hit_cnt, 32'd0);
        chk("miss_cnt", miss_cnt, 32'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        mode_we = 0; mode_wd = 0; fill_en = 0; flush = 0; fill_vpn = '0; fill_ppn = '0;
        main_bus.inst_rden = 0; main_bus.inst_riaddr = '0;
        main_bus.data_rden = 0; main_bus.data_riaddr = '0;
        main_bus.data_wren = 0; main_bus.data_waddr = '0;
        main_bus.data_wstrb = '0; main_bus.data_wdata = '0;
        mem_bus.inst_roaddr = '0; mem_bus.inst_rvalid = 0; mem_bus.inst_rdata = '0;
        mem_bus.data_roaddr = '0; mem_bus.data_rvalid = 0; mem_bus.data_rdata = '0;
        mem_bus.stall = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic fill(input logic [VW-1:0] v, input logic [VW-1:0] p);
        fill_en = 1; fill_vpn = v; fill_ppn = p;
        step();
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state and bare-mode pass-through
        @(negedge clk);
        chk("rst_inst_fault", inst_fault, 0);
        chk("rst_fault_addr", fault_addr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h8000_0010;
        @(negedge clk);
        chk("bare_inst_riaddr", mem_bus.inst_riaddr, 32'h8000_0010);
        chk("bare_inst_rden", mem_bus.inst_rden, 1);
        step();
        @(negedge clk);
        chk("bare_no_fault", inst_fault, 0);

        // Translated data read and return path
        mode_we = 1; mode_wd = 1;
        fill(20'h80000, 20'h00012);
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h8000_0ABC;
        main_bus.data_wren = 1; main_bus.data_waddr = 32'h8000_0F00;
        main_bus.data_wstrb = 4'hA; main_bus.data_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("xl_data_riaddr", mem_bus.data_riaddr, 32'h0001_2ABC);
        chk("xl_data_waddr", mem_bus.data_waddr, 32'h0001_2F00);
        chk("xl_data_wstrb", mem_bus.data_wstrb, 4'hA);
        step();
        mem_bus.data_roaddr = 32'h0001_2ABC; mem_bus.data_rvalid = 1;
        mem_bus.data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ret_data_roaddr", main_bus.data_roaddr, 32'h8000_0ABC);
        chk("ret_data_rdata", main_bus.data_rdata, 32'hDEAD_BEEF);
        step();

        // Empty TLB write miss
        flush = 1;
        step();
        main_bus.data_wren = 1; main_bus.data_waddr = 32'h4000_0004;
        @(negedge clk);
        chk("miss_wren_squashed", mem_bus.data_wren, 0);
        step();
        @(negedge clk);
        chk("miss_data_fault", data_fault, 1);
        chk("miss_fault_addr", fault_addr, 32'h4000_0004);
        step();
        @(negedge clk);
        chk("miss_fault_one_cycle", data_fault, 0);

        // Round-robin eviction and in-place refill
        for (int i = 0; i < 5; i++) fill(20'h10000 + 20'(i), 20'h00100 + 20'(i));
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h1000_0000;
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h1000_1000;
        @(negedge clk);
        chk("evicted_first_miss", mem_bus.data_rden, 0);
        chk("second_still_hit", mem_bus.inst_riaddr, 32'h0010_1000);
        fill(20'h10002, 20'h00AAA);
        fill(20'h10005, 20'h00555);
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h1000_1000;
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h1000_2000;
        @(negedge clk);
        chk("victim_after_refill", mem_bus.inst_rden, 0);
        chk("refill_new_ppn", mem_bus.data_riaddr, 32'h00AA_A000);
        step();
        @(negedge clk);
        chk("refill_no_data_fault", data_fault, 0);

        // Simultaneous inst and data misses: data address wins
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h1000_0100;
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h1000_1200;
        step();
        @(negedge clk);
        chk("both_inst_fault", inst_fault, 1);
        chk("both_data_fault", data_fault, 1);
        chk("both_fault_addr", fault_addr, 32'h1000_1200);

        // Miss under stall raises no fault
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h7000_0000; mem_bus.stall = 1;
        step();
        @(negedge clk);
        chk("stall_no_fault", inst_fault, 0);

        // Flush beats a same-cycle fill
        flush = 1; fill_en = 1; fill_vpn = 20'h20000; fill_ppn = 20'h00222;
        step();
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h2000_0000;
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h1000_4000;
        @(negedge clk);
        chk("flush_fill_dropped", mem_bus.inst_rden, 0);
        chk("flush_all_miss", mem_bus.data_rden, 0);
        step();
        @(negedge clk);
        chk("pre_rst_fault", inst_fault, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_kills_inst_fault", inst_fault, 0);
        chk("rst_kills_data_fault", data_fault, 0);
        chk("rst_clears_fault_addr", fault_addr, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // Lookup counters: three hits, one miss, one stalled hit
        mode_we = 1; mode_wd = 1;
        fill(20'h30000, 20'h00333);
        for (int i = 0; i < 3; i++) begin
            main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h3000_0040 + 32'(i * 4);
            step();
        end
        main_bus.data_rden = 1; main_bus.data_riaddr = 32'h5000_0000;
        step();
        main_bus.inst_rden = 1; main_bus.inst_riaddr = 32'h3000_0000; mem_bus.stall = 1;
        step();
        @(negedge clk);
`ifdef MMU_TLB_PERF_EN
        chk("perf_hit_cnt", hit_cnt, 3);
        chk("perf_miss_cnt", miss_cnt, 1);
`else
        chk("perf_hit_cnt", hit_cnt, 0);
        chk("perf_miss_cnt", miss_cnt, 0);
`endif
        step();
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of TLB entries (power of two, 2..16).
REQ-002 SHALL have parameter PAGE_BITS, default 12, page-offset width; VPN/PPN width = 32-PAGE_BITS.
REQ-003 SHALL have parameter RESET_MODE, default 0, MODE value after reset (0 bare, 1 translate).
REQ-004 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port MODE_WE / MODE_WD  in  1/1  write strobe and value for the translation-mode register.
REQ-007 SHALL have port FILL_EN  in  1  write one TLB entry this cycle.
REQ-008 SHALL have port FILL_VPN / FILL_PPN  in  32-PAGE_BITS each  entry contents.
REQ-009 SHALL have port FLUSH  in  1  invalidate all entries.
REQ-010 SHALL have port INST_FAULT / DATA_FAULT  out  1/1  one-cycle translation-miss pulses.
REQ-011 SHALL have port FAULT_ADDR  out  32  virtual address of the most recent miss.
REQ-012 SHALL have port HIT_CNT / MISS_CNT  out  32/32  performance counters (see REQ-033).
REQ-013 SHALL have ports MAIN_INST_RDEN->MEM_INST_RDEN  in->out  1  instruction read request.
REQ-014 SHALL have ports MAIN_INST_RIADDR->MEM_INST_RIADDR  in->out  32  virtual->physical fetch address.
REQ-015 SHALL have ports MEM_INST_ROADDR->MAIN_INST_ROADDR  in->out  32  returned address, physical->virtual.
REQ-016 SHALL have ports MEM_INST_RVALID/RDATA->MAIN_INST_RVALID/RDATA  in->out  1/32  returned fetch.
REQ-017 SHALL have ports MAIN_DATA_RDEN/RIADDR->MEM_DATA_RDEN/RIADDR  in->out  1/32  data read request.
REQ-018 SHALL have ports MEM_DATA_ROADDR/RVALID/RDATA->MAIN_DATA_*  in->out  32/1/32  returned data read.
REQ-019 SHALL have ports MAIN_DATA_WREN/WADDR->MEM_DATA_WREN/WADDR  in->out  1/32  data write request.
REQ-020 SHALL have ports MAIN_DATA_WSTRB/WDATA->MEM_DATA_WSTRB/WDATA  in->out  4/32  passed unchanged.
REQ-021 SHALL have ports MEM_WAIT->MMU_WAIT  in->out  1  memory stall, forwarded.

Function
REQ-022 SHALL in bare mode pass every request/return combinationally unchanged; no faults, no counting.
REQ-023 SHALL in translate mode look up each of the three request addresses in parallel, combinationally, fully associative on VPN; hit -> output {PPN, offset}.
REQ-024 SHALL on miss suppress the corresponding MEM_*_RDEN/WREN (0) and, next cycle, pulse INST_FAULT (inst) or DATA_FAULT (data read or write) for exactly one cycle, capturing FAULT_ADDR.
REQ-025 SHALL on simultaneous inst and data misses pulse both faults; FAULT_ADDR takes the data address.
REQ-026 SHALL hold each channel's last issued VPN in a register, updated only on an issued read with MEM_WAIT=0; MAIN_*_ROADDR = {held VPN, MEM_*_ROADDR offset} (one outstanding read per channel).
REQ-027 SHALL on FILL_EN write into the entry already holding FILL_VPN if valid, else into the round-robin victim; the pointer advances (wrapping ENTRIES-1 -> 0) only on victim writes.
REQ-028 SHALL on FLUSH clear all valid bits and reset the pointer; FLUSH with FILL_EN same cycle -> flush wins, fill dropped.
REQ-029 SHALL let a lookup coincident with FILL_EN/FLUSH/MODE_WE see pre-update state.
REQ-030 SHALL, while MEM_WAIT=1, issue no fault pulses and hold all registers except TLB fill/flush.

Reset
REQ-031 SHALL on RST=0 asynchronously clear all valid bits, pointer, held VPNs, faults, FAULT_ADDR and counters to 0 and set MODE to RESET_MODE; combinational outputs follow inputs.

Configuration
REQ-032 SHALL compile counters only when MMU_TLB_PERF_EN is defined.
REQ-033 SHALL with MMU_TLB_PERF_EN count per-cycle translate-mode lookups (each channel separately, MEM_WAIT=0) into saturating HIT_CNT/MISS_CNT; without it, both tie to 0 and no counter flops exist.

Structure
REQ-034 SHALL place MODE_BARE/MODE_TRANSLATE constants and the page-field width function in shared package mmu_pkg.
REQ-035 SHALL implement the entry array plus three-port lookup as sub-module mmu_tlb_cam.

Verification
REQ-036 SHALL cover: reset, MODE=0, INST_RIADDR=0x8000_0010 -> MEM_INST_RIADDR=0x8000_0010, no fault.
REQ-037 SHALL cover: fill VPN 0x80000->PPN 0x00012, MODE=1, read 0x8000_0ABC -> MEM_DATA_RIADDR=0x0001_2ABC; MEM returns ROADDR 0x0001_2ABC -> MAIN_DATA_ROADDR=0x8000_0ABC.
REQ-038 SHALL cover: MODE=1, empty TLB, write 0x4000_0004 -> MEM_DATA_WREN=0, DATA_FAULT one cycle later, FAULT_ADDR=0x4000_0004.
REQ-039 SHALL cover: ENTRIES=4, five distinct fills -> first VPN evicted (misses), refill of resident VPN changes PPN without moving pointer.
REQ-040 SHALL cover: FLUSH with FILL_EN same cycle -> all lookups miss; RST low mid-fault -> fault deasserts immediately.
REQ-041 SHALL cover (MMU_TLB_PERF_EN): three hits then one miss with MEM_WAIT=0 -> HIT_CNT=3, MISS_CNT=1; MEM_WAIT=1 cycles not counted.
